// File: rtl/board_io_pkg.sv
// Shared board I/O constants: clock rate, default button timing and the
// button conditioner FSM state encoding.
package board_io_pkg;

    localparam int CLK_HZ = 50_000_000;

    // 20 ms debounce, 0.5 s initial repeat delay, 5 repeats per second
    localparam int DEBOUNCE_DEFAULT      = CLK_HZ / 50;
    localparam int REPEAT_DELAY_DEFAULT  = CLK_HZ / 2;
    localparam int REPEAT_PERIOD_DEFAULT = CLK_HZ / 5;

    localparam logic [1:0] RELEASED   = 2'd0;
    localparam logic [1:0] HOLD_DELAY = 2'd1;
    localparam logic [1:0] REPEATING  = 2'd2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous input; both stages reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Shift the raw pin through two flops to settle metastability
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: synchronise, debounce, and emit registered press,
// release and optional auto-repeat strobes.
module button_conditioner
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic level_out,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_MAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

    logic              sync_s;
    logic              rise_s;
    logic              fall_s;
    logic [DB_W-1:0]   db_cnt_d,  db_cnt_q;
    logic              level_d,   level_q;
    logic [1:0]        state_d,   state_q;
    logic [HOLD_W-1:0] hold_d,    hold_q;
    logic              press_d,   press_q;
    logic              release_d, release_q;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_in),
        .q     (sync_s)
    );

    // Stable-time debounce: level flips only after an unbroken disagreement run
    always_comb begin
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        if (sync_s != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d  = ~level_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end else begin
            db_cnt_d = '0;
        end
    end

    // Edges are taken from the next-state level so pulses align with level_out
    assign rise_s = level_d & ~level_q;
    assign fall_s = ~level_d & level_q;

    // Press/hold/repeat FSM; a falling level overrides any repeat due this cycle
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (fall_s) begin
            state_d   = RELEASED;
            hold_d    = '0;
            release_d = 1'b1;
        end else if (rise_s) begin
            state_d = HOLD_DELAY;
            hold_d  = '0;
            press_d = 1'b1;
        end else begin
            case (state_q)
                RELEASED: begin
                    hold_d = '0;
                end
                HOLD_DELAY: begin
                    if (hold_q == DELAY_LAST) begin
                        if (REPEAT_EN) begin
                            state_d = REPEATING;
                            hold_d  = '0;
                            press_d = 1'b1;
                        end else begin
                            hold_d = hold_q;
                        end
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                REPEATING: begin
                    if (hold_q == PERIOD_LAST) begin
                        hold_d  = '0;
                        press_d = 1'b1;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                default: begin
                    state_d = RELEASED;
                    hold_d  = '0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            state_q   <= RELEASED;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            state_q   <= state_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_out     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: one auto-repeat instance (a) and
// one single-press instance (b), both with short debounce/repeat timing.
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    typedef struct packed {
        int   cyc;
        logic lvl;
        logic prs;
        logic rel;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic btn_a = 1'b0;
    logic btn_b = 1'b0;
    logic lvl_a, prs_a, rel_a;
    logic lvl_b, prs_b, rel_b;
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;

    int cyc   = 0;
    int n_vec = 0;
    int n_err = 0;
    int b;

    ev_t qa[$];
    ev_t qb[$];

    button_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_EN       (1'b1),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_in        (btn_a),
        .level_out     (lvl_a),
        .press_pulse   (prs_a),
        .release_pulse (rel_a)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_EN       (1'b0),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_in        (btn_b),
        .level_out     (lvl_b),
        .press_pulse   (prs_b),
        .release_pulse (rel_b)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge number N, cyc == N
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_ev(input int idx, input int c, input logic l, input logic p, input logic r);
        ev_t e;
        e.cyc = c;
        e.lvl = l;
        e.prs = p;
        e.rel = r;
        if (idx == 0) qa.push_back(e);
        else          qb.push_back(e);
    endtask

    // Any pulse or level change is an output event to be matched in order
    task automatic watch(input int idx, input logic l, input logic p, input logic r);
        ev_t  got;
        ev_t  exp;
        logic prev;
        int   depth;
        prev  = (idx == 0) ? prev_a : prev_b;
        depth = (idx == 0) ? qa.size() : qb.size();
        if (p || r || (l != prev)) begin
            got.cyc = cyc;
            got.lvl = l;
            got.prs = p;
            got.rel = r;
            n_vec++;
            if (depth == 0) begin
                n_err++;
                $display("FAIL unexpected_event dut%0d: got cyc=%0d lvl=%b press=%b release=%b, required no event",
                         idx, got.cyc, got.lvl, got.prs, got.rel);
            end else begin
                if (idx == 0) exp = qa.pop_front();
                else          exp = qb.pop_front();
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL event dut%0d: got cyc=%0d lvl=%b press=%b release=%b, required cyc=%0d lvl=%b press=%b release=%b",
                             idx, got.cyc, got.lvl, got.prs, got.rel, exp.cyc, exp.lvl, exp.prs, exp.rel);
                end
            end
        end
        if (idx == 0) prev_a = l;
        else          prev_b = l;
    endtask

    always @(negedge clk) begin
        watch(0, lvl_a, prs_a, rel_a);
        watch(1, lvl_b, prs_b, rel_b);
    end

    // Every expected event consumed and all outputs back at rest
    task automatic check_idle(input string name);
        n_vec++;
        if ((qa.size() + qb.size()) != 0) begin
            n_err++;
            $display("FAIL %s_pending: got %0d unmatched expected events, required 0", name, qa.size() + qb.size());
        end
        qa.delete();
        qb.delete();
        n_vec++;
        if ({lvl_a, prs_a, rel_a, lvl_b, prs_b, rel_b} !== 6'b000000) begin
            n_err++;
            $display("FAIL %s_outputs: got %b, required 000000", name, {lvl_a, prs_a, rel_a, lvl_b, prs_b, rel_b});
        end
    endtask

    // Advance to 1 time unit after posedge number t
    task automatic at_cycle(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        at_cycle(cyc + 4);
        check_idle("reset");

        // Clean press with repeats, then release colliding with a repeat slot
        b = cyc + 1;
        btn_a = 1'b1;
        expect_ev(0, b + 5, 1'b1, 1'b1, 1'b0);
        for (int r = 15; r <= 30; r += 3) expect_ev(0, b + r, 1'b1, 1'b1, 1'b0);
        expect_ev(0, b + 33, 1'b0, 1'b0, 1'b1);
        at_cycle(b + 27);
        btn_a = 1'b0;
        at_cycle(b + 45);
        check_idle("press_repeat_collision");

        // Bounce: 2-cycle high/low toggles never settle long enough
        for (int i = 0; i < 4; i++) begin
            btn_a = (i % 2 == 0) ? 1'b1 : 1'b0;
            at_cycle(cyc + 2);
        end
        btn_a = 1'b0;
        at_cycle(cyc + 12);
        check_idle("bounce");

        // Longest rejected glitch: 3 cycles high
        btn_a = 1'b1;
        at_cycle(cyc + 3);
        btn_a = 1'b0;
        at_cycle(cyc + 12);
        check_idle("glitch3");

        // Shortest accepted press: exactly DEBOUNCE_CYCLES high
        b = cyc + 1;
        btn_a = 1'b1;
        expect_ev(0, b + 5, 1'b1, 1'b1, 1'b0);
        expect_ev(0, b + 9, 1'b0, 1'b0, 1'b1);
        at_cycle(cyc + 4);
        btn_a = 1'b0;
        at_cycle(b + 20);
        check_idle("pulse4");

        // No auto-repeat: long hold yields one press and one release
        b = cyc + 1;
        btn_b = 1'b1;
        expect_ev(1, b + 5, 1'b1, 1'b1, 1'b0);
        at_cycle(b + 100);
        btn_b = 1'b0;
        expect_ev(1, b + 106, 1'b0, 1'b0, 1'b1);
        at_cycle(b + 120);
        check_idle("no_repeat");

        // Reset while held: outputs drop at once, press is re-detected
        b = cyc + 1;
        btn_a = 1'b1;
        expect_ev(0, b + 5, 1'b1, 1'b1, 1'b0);
        at_cycle(b + 8);
        expect_ev(0, b + 8, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        at_cycle(cyc + 3);
        rst_n = 1'b1;
        b = cyc + 1;
        expect_ev(0, b + 5, 1'b1, 1'b1, 1'b0);
        at_cycle(b + 7);
        btn_a = 1'b0;
        expect_ev(0, b + 13, 1'b0, 1'b0, 1'b1);
        at_cycle(b + 25);
        check_idle("reset_mid_hold");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
